// File: rtl/ysyx_22040088_pkg.sv
// ysyx_22040088_pkg: shared LSU constants, size encodings, FSM state codes and strobe-mask helper
package ysyx_22040088_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t S_IDLE = 2'd0;
    localparam lsu_state_t S_REQ  = 2'd1;
    localparam lsu_state_t S_WAIT = 2'd2;
    localparam lsu_state_t S_RESP = 2'd3;

    function automatic logic [7:0] strb_mask(input logic [1:0] size);
        return size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
    endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_align.sv
// ysyx_22040088_lsu_align: store lane shift, strobe generation and load extract/extend
// Ports: size/uns/wen/off describe the access; wdata is right-aligned store data,
// rdata the aligned memory doubleword; outputs are lane-placed wstrb/wdata_sh and
// the extended load result load_data.
module ysyx_22040088_lsu_align
    import ysyx_22040088_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic            wen,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] load_data
);

    logic [5:0]      sh;
    logic [XLEN-1:0] raw;

    always_comb begin
        sh        = {off, 3'b000};
        wstrb     = wen ? strb_mask(size) << off : 8'h00;
        wdata_sh  = wdata << sh;
        raw       = rdata >> sh;
        load_data = size == SZ_B ? {{(XLEN-8){~uns & raw[7]}}, raw[7:0]} :
                    size == SZ_H ? {{(XLEN-16){~uns & raw[15]}}, raw[15:0]} :
                    size == SZ_W ? {{(XLEN-32){~uns & raw[31]}}, raw[31:0]} : raw;
    end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// ysyx_22040088_lsu: multi-cycle load/store unit between the EXU and a 64-bit data memory port
// Ports: req_* is the EXU request handshake, mem_req_*/mem_resp_* the memory port,
// resp_* the extended result toward write-back; rst is asynchronous active-low.
module ysyx_22040088_lsu #(
    parameter int XLEN          = 64,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [7:0]      mem_req_wstrb,
    output logic [XLEN-1:0] mem_req_wdata,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err
);

    import ysyx_22040088_pkg::*;

    lsu_state_t      state_q, state_d;
    logic            wen_q, wen_d, uns_q, uns_d, resp_err_q, resp_err_d;
    logic [1:0]      size_q, size_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, resp_data_q, resp_data_d;
    logic [XLEN-1:0] load_data;
    logic [2:0]      lo_mask;
    logic            trap;

    ysyx_22040088_lsu_align u_align (
        .size      (size_q),
        .uns       (uns_q),
        .wen       (wen_q),
        .off       (addr_q[2:0]),
        .wdata     (wdata_q),
        .rdata     (mem_resp_rdata),
        .wstrb     (mem_req_wstrb),
        .wdata_sh  (mem_req_wdata),
        .load_data (load_data)
    );

    always_comb begin
        lo_mask     = req_size == SZ_B ? 3'd0 : req_size == SZ_H ? 3'd1 : req_size == SZ_W ? 3'd3 : 3'd7;
        trap        = MISALIGN_TRAP && |(req_addr[2:0] & lo_mask);
        state_d     = state_q;
        wen_d       = wen_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                wen_d       = req_wen;
                size_d      = req_size;
                uns_d       = req_unsigned;
                wdata_d     = req_wdata;
                // Without trapping, misaligned low bits are dropped to natural alignment
                addr_d      = MISALIGN_TRAP ? req_addr : req_addr & ~{{(XLEN-3){1'b0}}, lo_mask};
                resp_err_d  = trap;
                resp_data_d = '0;
                state_d     = trap ? S_RESP : S_REQ;
            end
            S_REQ:  state_d = mem_req_ready ? S_WAIT : S_REQ;
            S_WAIT: if (mem_resp_valid) begin
                resp_data_d = wen_q ? '0 : load_data;
                state_d     = S_RESP;
            end
            default: state_d = resp_ready ? S_IDLE : S_RESP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wen_q       <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready     = state_q == S_IDLE;
    assign mem_req_valid = state_q == S_REQ;
    assign resp_valid    = state_q == S_RESP;
    assign mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign mem_req_wen   = wen_q;
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// tb_ysyx_22040088_lsu: directed self-checking bench for the load/store unit
module tb_ysyx_22040088_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [63:0] resp_data;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    ysyx_22040088_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err)
    );

    always @(posedge clk) if (rst && mem_req_valid && mem_req_ready) hs_cnt <= hs_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic wen, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                           input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                           input logic [63:0] exp_wdata, input logic [63:0] exp_data);
        @(negedge clk);
        check({tag, ".req_ready"}, req_ready, 1);
        issue(wen, size, uns, addr, wdata);
        check({tag, ".mem_valid"}, mem_req_valid, 1);
        check({tag, ".mem_addr"}, mem_req_addr, exp_addr);
        check({tag, ".wstrb"}, mem_req_wstrb, exp_strb);
        check({tag, ".mem_wen"}, mem_req_wen, wen);
        if (wen) check({tag, ".mem_wdata"}, mem_req_wdata, exp_wdata);
        check({tag, ".busy"}, req_ready, 0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check({tag, ".mem_drop"}, mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check({tag, ".resp_valid"}, resp_valid, 1);
        check({tag, ".resp_data"}, resp_data, exp_data);
        check({tag, ".resp_err"}, resp_err, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, ".idle"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        logic [63:0] held_addr, held_data;
        int hs0;
        #1;
        check("rst.req_ready", req_ready, 1);
        check("rst.resp_valid", resp_valid, 0);
        check("rst.mem_valid", mem_req_valid, 0);
        check("rst.resp_err", resp_err, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        run_txn("lw",  0, 2, 0, 64'h8000_0004, 0, 64'h8000_0000_1234_5678,
                64'h8000_0000, 8'h00, 0, 64'hFFFF_FFFF_8000_0000);
        run_txn("lwu", 0, 2, 1, 64'h8000_0004, 0, 64'h8000_0000_1234_5678,
                64'h8000_0000, 8'h00, 0, 64'h0000_0000_8000_0000);
        run_txn("lh",  0, 1, 0, 64'h8000_0006, 0, 64'h8001_0000_0000_0000,
                64'h8000_0000, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001);
        run_txn("lhu", 0, 1, 1, 64'h8000_0006, 0, 64'h8001_0000_0000_0000,
                64'h8000_0000, 8'h00, 0, 64'h0000_0000_0000_8001);
        run_txn("lb",  0, 0, 0, 64'h8000_0001, 0, 64'h1122_3344_5566_7788,
                64'h8000_0000, 8'h00, 0, 64'h0000_0000_0000_0077);
        run_txn("lbs", 0, 0, 0, 64'h8000_0000, 0, 64'h1122_3344_5566_7788,
                64'h8000_0000, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF88);
        run_txn("ld",  0, 3, 1, 64'h8000_0008, 0, 64'hF122_3344_5566_7788,
                64'h8000_0008, 8'h00, 0, 64'hF122_3344_5566_7788);
        run_txn("sb",  1, 0, 0, 64'h8000_0003, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000, 0);
        run_txn("sh",  1, 1, 0, 64'h8000_000A, 64'h1234, 0,
                64'h8000_0008, 8'h0C, 64'h0000_0000_1234_0000, 0);
        run_txn("sd",  1, 3, 0, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 0,
                64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 0);

        // misaligned doubleword load traps straight to a response
        @(negedge clk);
        hs0 = hs_cnt;
        issue(0, 3, 0, 64'h8000_0004, 0);
        check("mis.resp_valid", resp_valid, 1);
        check("mis.resp_err", resp_err, 1);
        check("mis.resp_data", resp_data, 0);
        check("mis.mem_valid", mem_req_valid, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("mis.mem_valid2", mem_req_valid, 0);
        check("mis.idle", req_ready, 1);
        check("mis.no_hs", hs_cnt, hs0);

        // backpressure on both sides; a response overlapping the request handshake is ignored
        @(negedge clk);
        hs0 = hs_cnt;
        issue(0, 2, 0, 64'h8000_0000, 0);
        for (int i = 0; i < 3; i++) begin
            check("bp.mem_valid", mem_req_valid, 1);
            check("bp.mem_addr", mem_req_addr, 64'h8000_0000);
            check("bp.wstrb", mem_req_wstrb, 0);
            check("bp.busy", req_ready, 0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1111_1111_2222_2222;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(negedge clk);
        check("bp.early_resp_ignored", resp_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hCAFE_BABE_DEAD_BEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        held_data = 64'hFFFF_FFFF_DEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            check("bp.resp_valid", resp_valid, 1);
            check("bp.resp_data", resp_data, held_data);
            check("bp.busy2", req_ready, 0);
            if (i == 2) resp_ready = 1'b1;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        check("bp.idle", req_ready, 1);
        check("bp.one_hs", hs_cnt - hs0, 1);

        // stalled store keeps its request fields stable
        issue(1, 2, 0, 64'h8000_0004, 64'h1122_3344);
        held_addr = mem_req_addr;
        for (int i = 0; i < 3; i++) begin
            check("st.addr_stable", mem_req_addr, 64'h8000_0000);
            check("st.wstrb", mem_req_wstrb, 8'hF0);
            check("st.wdata", mem_req_wdata, 64'h1122_3344_0000_0000);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("st.resp_data", resp_data, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // reset while waiting for the memory response
        issue(0, 3, 0, 64'h8000_0000, 0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("rw.resp_valid", resp_valid, 0);
        check("rw.req_ready", req_ready, 1);
        check("rw.mem_valid", mem_req_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h5555_5555_5555_5555;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("rw.stale1", resp_valid, 0);
        @(negedge clk);
        check("rw.stale2", resp_valid, 0);
        check("rw.idle", req_ready, 1);

        // the LSU is usable again after the mid-transaction reset
        run_txn("post", 0, 1, 0, 64'h8000_0002, 0, 64'h0000_0000_7FFF_0000,
                64'h8000_0000, 8'h00, 0, 64'h0000_0000_0000_7FFF);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
